// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side helpers: read-latency modes and
// the depth of the output skid buffer.
package fifo_pkg;

  localparam bit FIFO_FWFT = 1'b1;
  localparam bit FIFO_REG  = 1'b0;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry ordered buffer with 1-bit head/tail pointers and an occupancy
// count; push and pop in the same cycle keep occupancy and order intact.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [width-1:0] din_i,
  input  logic             pop_i,
  output logic [width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output skid_cnt_t        count_o
);

  logic [width-1:0] mem_q [SKID_DEPTH];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  skid_cnt_t        cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == skid_cnt_t'(SKID_DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = ~wr_q;
    if (do_pop)  rd_d = ~rd_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + skid_cnt_t'(1);
      2'b01:   cnt_d = cnt_q - skid_cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO into a valid/ready stream, hiding whether the FIFO is
// first-word-fall-through or has a registered read port.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter bit fwft_enable = FIFO_FWFT,
  parameter int width       = 16,
  parameter int cnt_width   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [width-1:0]     fifo_data,
  output logic                 fifo_re,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [width-1:0]     m_data,
  output logic [cnt_width-1:0] xfer_count,
  output logic                 busy
);

  logic                 inflight_q, inflight_d;
  logic [cnt_width-1:0] xfer_q, xfer_d;
  logic                 pop, push;
  logic                 skid_full, skid_empty;
  skid_cnt_t            occ;
  logic [2:0]           committed;

  assign pop = m_valid & m_ready;

  // Credit: words held plus words on their way must fit after this cycle's pop.
  assign committed = 3'({1'b0, occ}) + 3'({2'b0, inflight_q});
  assign fifo_re   = en & ~fifo_empty & ~rst & (committed < (3'd2 + 3'({2'b0, pop})));

  // A registered-read FIFO shows the word one cycle after re, so it is tracked as in flight.
  always_comb begin
    inflight_d = fwft_enable ? 1'b0 : fifo_re;
    push       = fwft_enable ? fifo_re : inflight_q;
    xfer_d     = pop ? xfer_q + cnt_width'(1) : xfer_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      xfer_q     <= xfer_d;
      assert (!(push && skid_full && !pop));
    end
  end

  stream_skid_buf #(.width(width)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .din_i  (fifo_data),
    .pop_i  (pop),
    .dout_o (m_data),
    .full_o (skid_full),
    .empty_o(skid_empty),
    .count_o(occ)
  );

  assign m_valid    = ~skid_empty;
  assign busy       = ~skid_empty | inflight_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Two readers (FWFT with a 4-bit counter, registered-read with a 16-bit
// counter), each fed by a small FIFO model; a monitor scores delivered words.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst0, rst1, en0, en1, mr0, mr1;
  logic        re0, re1, mv0, mv1, busy0, busy1, emp0, emp1;
  logic [15:0] fd0, fd1, md0, md1;
  logic [15:0] rdata1 = 16'h0;
  logic [3:0]  xc0;
  logic [15:0] xc1;
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  int          rp0 = 0, wp0 = 0, rp1 = 0, wp1 = 0;
  logic [15:0] exp0 [$];
  logic [15:0] exp1 [$];

  fifo_stream_reader #(.fwft_enable(1'b1), .width(16), .cnt_width(4)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .fifo_empty(emp0), .fifo_data(fd0),
    .fifo_re(re0), .m_valid(mv0), .m_ready(mr0), .m_data(md0),
    .xfer_count(xc0), .busy(busy0)
  );

  fifo_stream_reader #(.fwft_enable(1'b0), .width(16), .cnt_width(16)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .fifo_empty(emp1), .fifo_data(fd1),
    .fifo_re(re1), .m_valid(mv1), .m_ready(mr1), .m_data(md1),
    .xfer_count(xc1), .busy(busy1)
  );

  // FIFO models: instance 0 shows its head word, instance 1 registers the read.
  assign emp0 = (rp0 == wp0);
  assign fd0  = mem0[rp0[5:0]];
  assign emp1 = (rp1 == wp1);
  assign fd1  = rdata1;

  always @(posedge clk) begin
    if (rst0) rp0 <= wp0;
    else if (re0) rp0 <= rp0 + 1;
    if (rst1) rp1 <= wp1;
    else if (re1) begin
      rp1    <= rp1 + 1;
      rdata1 <= mem1[rp1[5:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push0(input logic [15:0] v);
    mem0[wp0[5:0]] = v;
    wp0++;
    exp0.push_back(v);
  endtask

  task automatic push1(input logic [15:0] v);
    mem1[wp1[5:0]] = v;
    wp1++;
    exp1.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!rst0 && mv0 && mr0) begin
      if (exp0.size() == 0) check("dut0_unexpected_word", 32'(md0), 32'hFFFF_FFFF);
      else check("dut0_data", 32'(md0), 32'(exp0.pop_front()));
    end
    if (!rst1 && mv1 && mr1) begin
      if (exp1.size() == 0) check("dut1_unexpected_word", 32'(md1), 32'hFFFF_FFFF);
      else check("dut1_data", 32'(md1), 32'(exp1.pop_front()));
    end
    check("dut0_re_while_empty", 32'(re0 & emp0), 0);
    check("dut1_re_while_empty", 32'(re1 & emp1), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nre;
    rst0 = 1'b1; rst1 = 1'b1;
    en0  = 1'b0; en1  = 1'b0;
    mr0  = 1'b1; mr1  = 1'b1;
    cyc(); cyc(); neg();
    check("rst0_valid", 32'(mv0), 0);
    check("rst0_data",  32'(md0), 0);
    check("rst0_count", 32'(xc0), 0);
    check("rst0_re",    32'(re0), 0);
    check("rst0_busy",  32'(busy0), 0);
    check("rst1_valid", 32'(mv1), 0);
    check("rst1_data",  32'(md1), 0);
    check("rst1_count", 32'(xc1), 0);
    check("rst1_re",    32'(re1), 0);
    check("rst1_busy",  32'(busy1), 0);
    cyc();
    rst0 = 1'b0; rst1 = 1'b0;

    // FWFT: four words, one per clock, first valid one cycle after the first read.
    for (int k = 1; k <= 4; k++) push0(16'(k));
    en0 = 1'b1;
    neg();
    check("fwft_first_re", 32'(re0), 1);
    check("fwft_no_early_valid", 32'(mv0), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); neg();
      check("fwft_stream_valid", 32'(mv0), 1);
      check("fwft_stream_data", 32'(md0), 32'(k));
    end
    cyc(); neg();
    check("fwft_idle_busy", 32'(busy0), 0);
    check("fwft_idle_valid", 32'(mv0), 0);
    check("fwft_count4", 32'(xc0), 4);

    // Backpressure: five words queued, downstream stalled for six cycles.
    cyc();
    mr0 = 1'b0;
    for (int k = 1; k <= 5; k++) push0(16'(k));
    nre = 0;
    for (int k = 0; k < 6; k++) begin
      neg();
      nre += int'(re0);
      cyc();
    end
    check("bp_read_count", 32'(nre), 2);
    neg();
    check("bp_hold_valid", 32'(mv0), 1);
    check("bp_hold_data", 32'(md0), 32'h0001);
    check("bp_hold_no_re", 32'(re0), 0);
    cyc();
    mr0 = 1'b1;
    for (int k = 0; k < 12 && busy0; k++) cyc();
    neg();
    check("bp_drained_busy", 32'(busy0), 0);
    check("bp_count9", 32'(xc0), 9);
    check("bp_all_delivered", 32'(exp0.size()), 0);
    check("bp_fifo_empty", 32'(wp0 - rp0), 0);

    // Registered read: first valid two cycles after the first read.
    cyc();
    for (int k = 1; k <= 4; k++) push1(16'(k));
    en1 = 1'b1;
    neg();
    check("reg_first_re", 32'(re1), 1);
    cyc(); neg();
    check("reg_no_early_valid", 32'(mv1), 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(); neg();
      check("reg_stream_valid", 32'(mv1), 1);
      check("reg_stream_data", 32'(md1), 32'(k));
    end
    cyc(); neg();
    check("reg_idle_busy", 32'(busy1), 0);
    check("reg_count4", 32'(xc1), 4);

    // Drain disabled after two reads, the second still in flight.
    cyc();
    push1(16'h0011); push1(16'h0012); push1(16'h0013); push1(16'h0014);
    nre = 0;
    neg(); nre += int'(re1);
    cyc(); neg(); nre += int'(re1);
    cyc();
    en1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      neg();
      nre += int'(re1);
      cyc();
    end
    check("en_low_reads", 32'(nre), 2);
    check("en_low_count", 32'(xc1), 6);
    check("en_low_busy", 32'(busy1), 0);
    check("en_low_fifo_left", 32'(wp1 - rp1), 2);
    check("en_low_words_left", 32'(exp1.size()), 2);

    // Reset with one word buffered and one in flight, then a fresh word.
    mr1 = 1'b0;
    en1 = 1'b1;
    push1(16'h0015);
    cyc(); cyc();
    check("rst_mid_pre_valid", 32'(mv1), 1);
    check("rst_mid_pre_busy", 32'(busy1), 1);
    rst1 = 1'b1;
    exp1.delete();
    cyc();
    rst1 = 1'b0;
    neg();
    check("rst_mid_valid", 32'(mv1), 0);
    check("rst_mid_count", 32'(xc1), 0);
    check("rst_mid_busy", 32'(busy1), 0);
    check("rst_mid_data", 32'(md1), 0);
    cyc();
    mr1 = 1'b1;
    push1(16'hBEEF);
    for (int k = 0; k < 8 && xc1 != 16'd1; k++) cyc();
    neg();
    check("beef_count", 32'(xc1), 1);
    check("beef_busy", 32'(busy1), 0);
    check("beef_delivered", 32'(exp1.size()), 0);

    // Counter wrap with a 4-bit counter: 17 transfers leave it at 1.
    cyc();
    rst0 = 1'b1;
    cyc();
    rst0 = 1'b0;
    neg();
    check("wrap_start", 32'(xc0), 0);
    cyc();
    for (int k = 0; k < 17; k++) push0(16'(16'h0100 + k));
    cyc();
    for (int k = 0; k < 30 && busy0; k++) cyc();
    neg();
    check("wrap_count", 32'(xc0), 1);
    check("wrap_busy", 32'(busy0), 0);
    check("wrap_delivered", 32'(exp0.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
